corrupt_scheduler: RTL and testbench
====================================

// Module: corrupt_scheduler
// PURPOSE
//  Frame-aware controller for the sender-side byte corruptor in the map path. Tracks frame position from
//  valid/FAS and drives the corruptor's enable with a per-byte decision and an 8-bit XOR mask.
//  Supports off, continuous, periodic-burst and single-shot-burst modes. FAS and CRC bytes are never
//  corrupted. Reports corrupted-frame and resync counts to the hardware interface.
// PARAMETERS
//  ROWS      4       rows per frame
//  COLS      1041    bytes per row (cols 0..1040)
//  FAS_LEN   16      protected FAS bytes at row 0, cols 0..FAS_LEN-1
//  LFSR_SEED 8'hA5   mask LFSR reset value (nonzero)
// PORTS
//  i_clk              in   1   clock
//  i_rst_n            in   1   asynchronous reset, active low
//  i_pyld_data_valid  in   1   byte valid on the line
//  i_frame_data_fas   in   1   high with valid on the first byte (row 0, col 0) of a frame
//  i_mode             in   2   0 off, 1 continuous, 2 periodic burst, 3 single-shot burst
//  i_interval         in   8   periodic: corrupt 1 frame, then skip i_interval frames
//  i_offset           in   13  burst start, linear byte index row*COLS+col
//  i_burst_len        in   8   unprotected bytes per burst; 0 = none
//  i_trigger          in   1   single-shot request pulse
//  o_row_cnt          out  2   row of the current byte
//  o_col_cnt          out  11  col of the current byte
//  o_corrupt_en       out  1   corrupt the current byte
//  o_xor_mask         out  8   mask for the current byte; 0 when o_corrupt_en=0
//  o_synced           out  1   frame position locked
//  o_corrupt_frames   out  16  frames with >=1 corrupted byte, saturating
//  o_resync_cnt       out  8   unexpected-FAS resyncs, saturating
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state UNSYNC; counters 0; LFSR=LFSR_SEED; shadows 0; trigger pending 0.
//   Outputs: o_corrupt_en=0, o_xor_mask=0, o_synced=0, o_row/col_cnt=0, o_corrupt_frames=0, o_resync_cnt=0.
//   Reset mid-burst aborts the burst immediately. A partial frame is not counted.
//  Position: registered row/col hold the position expected for the next valid byte. They advance only
//   on valid bytes: col wraps COLS-1->0 with row+1, and row wraps ROWS-1->0.
//   o_row_cnt/o_col_cnt = (valid & fas) ? 0 : registered value.
//  Sync: FAS byte in UNSYNC -> locked. FAS arriving when the expected position != (0,0) -> resync:
//   position restarts at this byte and o_resync_cnt+1. Expected (0,0) with a valid byte but no FAS ->
//   UNSYNC. While UNSYNC: o_corrupt_en=0.
//  Shadowing: i_mode, i_interval, i_offset and i_burst_len are captured on every FAS byte.
//   Changes mid-frame take effect at the next frame start.
//  Trigger: an i_trigger pulse sets pending. Pending is consumed at the next FAS when the mode is 3.
//   A second trigger while pending is ignored.
//  FSM (advances on valid bytes only):
//   UNSYNC : on FAS -> PASS.
//   PASS   : at FAS, a frame is selected if one of these holds:
//             - mode 1;
//             - mode 2 and skip counter = 0 (skip reloads to i_interval; otherwise skip-1);
//             - mode 3 and pending.
//            Selected with burst_len>0 -> ARMED; else stay PASS.
//   ARMED  : when linear index == offset -> BURST, and this byte is burst byte 1.
//   BURST  : each unprotected valid byte decrements remaining. At 0 -> PASS.
//            End of frame truncates the burst -> PASS.
//  Mode 1 corrupts every unprotected byte of every frame; i_offset and i_burst_len are ignored.
//  Protected bytes: row 0 col<FAS_LEN, and row ROWS-1 col COLS-1 (CRC).
//   They are never corrupted and are not counted as burst bytes.
//  o_corrupt_en = valid & synced & (mode1 | state BURST, incl. entry byte) & ~protected.
//   Combinational, zero latency: it is sampled with the same byte by the corruptor.
//  LFSR: x^8+x^6+x^5+x^4+1, Galois, steps on every valid byte. Its state is never zero.
//   o_xor_mask = o_corrupt_en ? lfsr : 0.
//  o_corrupt_frames increments once per frame, on the first corrupted byte. Saturates at 16'hFFFF.
//  Offset beyond the frame (>= ROWS*COLS): burst never starts and the frame is not counted.
//  Simultaneous FAS and end of burst: the new frame's selection wins.
// TESTING
//  1. Reset, mode 0, 3 clean frames -> o_synced=1 after the 1st FAS; o_corrupt_en never 1; counters stay 0.
//  2. Mode 1, one frame -> en=0 on row0 cols 0..15 and on row3 col1040; en=1 on all 4147 other bytes;
//     mask nonzero and matches the LFSR model; o_corrupt_frames=1.
//  3. Mode 2, interval=2, offset=100, len=5, 6 frames -> frames 1 and 4 are corrupted at
//     indices 100..104 only; o_corrupt_frames=2.
//  4. Mode 3, offset=4160, len=8, trigger mid-frame -> next frame corrupts indices 4160..4162 only
//     (CRC protected, burst truncated); the frame after is clean.
//  5. FAS injected at row1 col20 -> o_resync_cnt=1 and position restarts at 0,0;
//     a missing FAS at the wrap drops o_synced to 0 with no corruption.
//  6. Assert i_rst_n low during a BURST with valid gaps -> outputs are 0 immediately;
//     after release, o_corrupt_en stays 0 until the next FAS.

Source files
------------

// File: rtl/corrupt_scheduler.sv
// rtl/corrupt_scheduler.sv - frame-aware scheduler driving the map-path byte corruptor
// Tracks row/col from valid/FAS and decides per byte whether to corrupt and with which mask.

module corrupt_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_step,
   output logic [7:0] o_state
);
   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   // Galois form of x^8+x^6+x^5+x^4+1; a nonzero seed never reaches the all-zero state
   always_comb begin
      lfsr_d = lfsr_q;
      if (i_step) begin
         lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_state = lfsr_q;
endmodule

module corrupt_scheduler #(
   parameter int unsigned ROWS      = 4,
   parameter int unsigned COLS      = 1041,
   parameter int unsigned FAS_LEN   = 16,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_pyld_data_valid,
   input  logic        i_frame_data_fas,
   input  logic [1:0]  i_mode,
   input  logic [7:0]  i_interval,
   input  logic [12:0] i_offset,
   input  logic [7:0]  i_burst_len,
   input  logic        i_trigger,
   output logic [1:0]  o_row_cnt,
   output logic [10:0] o_col_cnt,
   output logic        o_corrupt_en,
   output logic [7:0]  o_xor_mask,
   output logic        o_synced,
   output logic [15:0] o_corrupt_frames,
   output logic [7:0]  o_resync_cnt
);
   localparam logic [1:0]  ROW_LAST      = 2'(ROWS - 1);
   localparam logic [10:0] COL_LAST      = 11'(COLS - 1);
   localparam logic [10:0] FAS_END       = 11'(FAS_LEN);
   localparam logic [12:0] COLS_W        = 13'(COLS);
   localparam logic [1:0]  MODE_CONT     = 2'd1;
   localparam logic [1:0]  MODE_PERIODIC = 2'd2;
   localparam logic [1:0]  MODE_SINGLE   = 2'd3;

   typedef enum logic [1:0] {ST_UNSYNC, ST_PASS, ST_ARMED, ST_BURST} state_t;

   state_t      state_q, state_d;
   logic        synced_q, synced_d;
   logic [1:0]  row_q, row_d;
   logic [10:0] col_q, col_d;
   logic [1:0]  mode_q, mode_d;
   logic [12:0] offset_q, offset_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  skip_q, skip_d;
   logic [7:0]  rem_q, rem_d;
   logic        pending_q, pending_d;
   logic        hit_q, hit_d;
   logic [15:0] frames_q, frames_d;
   logic [7:0]  resync_q, resync_d;

   logic        fas_byte;
   logic        synced;
   logic        at_origin;
   logic [1:0]  cur_row;
   logic [10:0] cur_col;
   logic [12:0] lin_idx;
   logic        is_eof;
   logic        is_prot;
   logic [1:0]  cur_mode;
   logic [12:0] cur_offset;
   logic [7:0]  cur_len;
   logic        sel_frame;
   logic        arm_now;
   logic        burst_start;
   logic        in_burst;
   logic        burst_byte;
   logic [7:0]  rem_base;
   logic [7:0]  rem_next;
   logic        frame_hit;
   logic        corrupt_en;
   logic [7:0]  lfsr_state;

   corrupt_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_step  (i_pyld_data_valid),
      .o_state (lfsr_state)
   );

   // Position and per-byte classification of the byte currently on the line
   always_comb begin
      fas_byte   = i_pyld_data_valid & i_frame_data_fas;
      synced     = (state_q != ST_UNSYNC);
      at_origin  = (row_q == 2'd0) && (col_q == 11'd0);
      cur_row    = fas_byte ? 2'd0 : row_q;
      cur_col    = fas_byte ? 11'd0 : col_q;
      lin_idx    = 13'(cur_row) * COLS_W + 13'(cur_col);
      is_eof     = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      is_prot    = ((cur_row == 2'd0) && (cur_col < FAS_END)) || is_eof;
      cur_mode   = fas_byte ? i_mode      : mode_q;
      cur_offset = fas_byte ? i_offset    : offset_q;
      cur_len    = fas_byte ? i_burst_len : len_q;
      frame_hit  = fas_byte ? 1'b0 : hit_q;
   end

   // Burst scheduling: a new FAS always re-evaluates selection, aborting any burst in flight
   always_comb begin
      sel_frame   = fas_byte & synced &
                    (((i_mode == MODE_PERIODIC) && (skip_q == 8'd0)) ||
                     ((i_mode == MODE_SINGLE) && pending_q));
      arm_now     = (sel_frame & (i_burst_len != 8'd0)) |
                    (i_pyld_data_valid & ~fas_byte & (state_q == ST_ARMED));
      burst_start = arm_now & (lin_idx == cur_offset);
      in_burst    = burst_start | (i_pyld_data_valid & ~fas_byte & (state_q == ST_BURST));
      burst_byte  = in_burst & ~is_prot;
      rem_base    = burst_start ? cur_len : rem_q;
      rem_next    = burst_byte ? (rem_base - 8'd1) : rem_base;
      corrupt_en  = i_pyld_data_valid & synced & ~is_prot &
                    ((cur_mode == MODE_CONT) | in_burst);
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      mode_d    = mode_q;
      offset_d  = offset_q;
      len_d     = len_q;
      skip_d    = skip_q;
      rem_d     = rem_q;
      pending_d = pending_q;
      hit_d     = hit_q;
      frames_d  = frames_q;
      resync_d  = resync_q;

      if (i_pyld_data_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = 11'd0;
            row_d = (cur_row == ROW_LAST) ? 2'd0 : (cur_row + 2'd1);
         end else begin
            col_d = cur_col + 11'd1;
            row_d = cur_row;
         end
         hit_d = frame_hit | corrupt_en;
         if (corrupt_en && !frame_hit && (frames_q != 16'hFFFF)) begin
            frames_d = frames_q + 16'd1;
         end
      end

      if (fas_byte) begin
         mode_d   = i_mode;
         offset_d = i_offset;
         len_d    = i_burst_len;
      end

      if (fas_byte && synced && !at_origin && (resync_q != 8'hFF)) begin
         resync_d = resync_q + 8'd1;
      end

      // The skip counter doubles as the captured interval: it reloads only when a frame is taken
      if (fas_byte && synced && (i_mode == MODE_PERIODIC)) begin
         skip_d = (skip_q == 8'd0) ? i_interval : (skip_q - 8'd1);
      end

      if (fas_byte && synced && (i_mode == MODE_SINGLE)) begin
         pending_d = 1'b0;
      end else if (i_trigger) begin
         pending_d = 1'b1;
      end

      if (in_burst) begin
         rem_d = rem_next;
      end

      if (in_burst) begin
         state_d = ((rem_next == 8'd0) || is_eof) ? ST_PASS : ST_BURST;
      end else if (arm_now) begin
         state_d = is_eof ? ST_PASS : ST_ARMED;
      end else if (fas_byte) begin
         state_d = ST_PASS;
      end else if (i_pyld_data_valid && synced && at_origin) begin
         state_d = ST_UNSYNC;
      end

      synced_d = (state_d != ST_UNSYNC);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_UNSYNC;
         synced_q  <= 1'b0;
         row_q     <= 2'd0;
         col_q     <= 11'd0;
         mode_q    <= 2'd0;
         offset_q  <= 13'd0;
         len_q     <= 8'd0;
         skip_q    <= 8'd0;
         rem_q     <= 8'd0;
         pending_q <= 1'b0;
         hit_q     <= 1'b0;
         frames_q  <= 16'd0;
         resync_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         synced_q  <= synced_d;
         row_q     <= row_d;
         col_q     <= col_d;
         mode_q    <= mode_d;
         offset_q  <= offset_d;
         len_q     <= len_d;
         skip_q    <= skip_d;
         rem_q     <= rem_d;
         pending_q <= pending_d;
         hit_q     <= hit_d;
         frames_q  <= frames_d;
         resync_q  <= resync_d;
      end
   end

   assign o_row_cnt        = cur_row;
   assign o_col_cnt        = cur_col;
   assign o_corrupt_en     = corrupt_en;
   assign o_xor_mask       = corrupt_en ? lfsr_state : 8'h00;
   assign o_synced         = synced_q;
   assign o_corrupt_frames = frames_q;
   assign o_resync_cnt     = resync_q;
endmodule

// File: tb/tb_corrupt_scheduler.sv
// tb/tb_corrupt_scheduler.sv - directed self-checking bench for corrupt_scheduler
// Streams whole frames and compares every byte against expected corrupt ranges and an LFSR model.

module tb_corrupt_scheduler;
   localparam int ROWS    = 4;
   localparam int COLS    = 1041;
   localparam int FAS_LEN = 16;
   localparam int FRAME   = ROWS * COLS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        fas = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [7:0]  interval = 8'd0;
   logic [12:0] offset = 13'd0;
   logic [7:0]  burst_len = 8'd0;
   logic        trig = 1'b0;
   logic [1:0]  row_cnt;
   logic [10:0] col_cnt;
   logic        corrupt_en;
   logic [7:0]  xor_mask;
   logic        synced;
   logic [15:0] corrupt_frames;
   logic [7:0]  resync_cnt;

   int          n_total = 0;
   int          n_pass = 0;
   int          seq_en = 0;
   logic [7:0]  lfsr_m = 8'hA5;

   always #5 clk = ~clk;

   corrupt_scheduler dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_pyld_data_valid (valid),
      .i_frame_data_fas  (fas),
      .i_mode            (mode),
      .i_interval        (interval),
      .i_offset          (offset),
      .i_burst_len       (burst_len),
      .i_trigger         (trig),
      .o_row_cnt         (row_cnt),
      .o_col_cnt         (col_cnt),
      .o_corrupt_en      (corrupt_en),
      .o_xor_mask        (xor_mask),
      .o_synced          (synced),
      .o_corrupt_frames  (corrupt_frames),
      .o_resync_cnt      (resync_cnt)
   );

   // x^8+x^6+x^5+x^4+1 shifted right, feedback into taps 8,6,5,4
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
   endfunction

   function automatic bit is_prot(input int idx);
      int r;
      int c;
      r = idx / COLS;
      c = idx % COLS;
      return ((r == 0) && (c < FAS_LEN)) || ((r == ROWS - 1) && (c == COLS - 1));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send_seq(input string tag, input bit fas_first, input int n, input int lo,
                           input int hi, input bit all_bytes, input bit live, input int trig_at);
      int         bad;
      int         first_bad;
      int         zero_mask;
      bit         exp_en;
      logic [7:0] exp_mask;
      bad       = 0;
      first_bad = -1;
      zero_mask = 0;
      seq_en    = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid    = 1'b1;
         fas      = fas_first && (i == 0);
         trig     = (i == trig_at);
         exp_en   = live && !is_prot(i) && (all_bytes || ((i >= lo) && (i <= hi)));
         exp_mask = exp_en ? lfsr_m : 8'h00;
         #1;
         if ((corrupt_en !== exp_en) || (xor_mask !== exp_mask) ||
             (row_cnt !== 2'(i / COLS)) || (col_cnt !== 11'(i % COLS))) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
         if (corrupt_en === 1'b1) seq_en++;
         if ((corrupt_en === 1'b1) && (xor_mask === 8'h00)) zero_mask++;
         lfsr_m = lfsr_next(lfsr_m);
      end
      @(negedge clk);
      valid = 1'b0;
      fas   = 1'b0;
      trig  = 1'b0;
      check($sformatf("%s byte errors (first idx %0d)", tag, first_bad), bad, 0);
      check($sformatf("%s zero masks", tag), zero_mask, 0);
   endtask

   initial begin
      int         bad6;
      bit         e6;
      logic [7:0] m6;

      repeat (3) @(negedge clk);
      #1;
      check("rst corrupt_en", corrupt_en, 1'b0);
      check("rst xor_mask", xor_mask, 8'h00);
      check("rst synced", synced, 1'b0);
      check("rst row", row_cnt, 2'd0);
      check("rst col", col_cnt, 11'd0);
      check("rst frames", corrupt_frames, 16'd0);
      check("rst resync", resync_cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      mode = 2'd0;
      send_seq("t1 frame1", 1'b1, FRAME, -1, -1, 1'b0, 1'b1, -1);
      check("t1 synced after first FAS", synced, 1'b1);
      send_seq("t1 frame2", 1'b1, FRAME, -1, -1, 1'b0, 1'b1, -1);
      send_seq("t1 frame3", 1'b1, FRAME, -1, -1, 1'b0, 1'b1, -1);
      check("t1 frames", corrupt_frames, 16'd0);
      check("t1 resync", resync_cnt, 8'd0);

      mode = 2'd1;
      send_seq("t2 continuous", 1'b1, FRAME, -1, -1, 1'b1, 1'b1, -1);
      check("t2 corrupted bytes", seq_en, 4147);
      check("t2 frames", corrupt_frames, 16'd1);

      mode      = 2'd2;
      interval  = 8'd2;
      offset    = 13'd100;
      burst_len = 8'd5;
      for (int f = 1; f <= 6; f++) begin
         send_seq($sformatf("t3 frame%0d", f), 1'b1, FRAME,
                  ((f == 1) || (f == 4)) ? 100 : -1, ((f == 1) || (f == 4)) ? 104 : -1,
                  1'b0, 1'b1, -1);
      end
      check("t3 frames (two more)", corrupt_frames, 16'd3);

      mode      = 2'd3;
      interval  = 8'd0;
      offset    = 13'd4160;
      burst_len = 8'd8;
      send_seq("t4 trigger frame", 1'b1, FRAME, -1, -1, 1'b0, 1'b1, 2000);
      send_seq("t4 burst frame", 1'b1, FRAME, 4160, 4162, 1'b0, 1'b1, -1);
      check("t4 truncated burst bytes", seq_en, 3);
      send_seq("t4 clean frame", 1'b1, FRAME, -1, -1, 1'b0, 1'b1, -1);
      check("t4 frames", corrupt_frames, 16'd4);

      mode = 2'd1;
      send_seq("t5 partial frame", 1'b1, COLS + 20, -1, -1, 1'b1, 1'b1, -1);
      check("t5 resync before", resync_cnt, 8'd0);
      send_seq("t5 resynced frame", 1'b1, FRAME, -1, -1, 1'b1, 1'b1, -1);
      check("t5 resync count", resync_cnt, 8'd1);
      check("t5 frames", corrupt_frames, 16'd6);
      send_seq("t5 missing FAS", 1'b0, 30, -1, -1, 1'b1, 1'b0, -1);
      check("t5 synced dropped", synced, 1'b0);
      check("t5 frames unchanged", corrupt_frames, 16'd6);

      mode      = 2'd2;
      interval  = 8'd0;
      offset    = 13'd30;
      burst_len = 8'd100;
      send_seq("t6 lock frame", 1'b1, FRAME, -1, -1, 1'b0, 1'b1, -1);
      check("t6 synced", synced, 1'b1);
      check("t6 lock is not a resync", resync_cnt, 8'd1);
      bad6 = 0;
      for (int i = 0; i < 40; i++) begin
         if ((i % 3) == 2) begin
            @(negedge clk);
            valid = 1'b0;
            fas   = 1'b0;
            #1;
            if ((corrupt_en !== 1'b0) || (xor_mask !== 8'h00)) bad6++;
         end
         @(negedge clk);
         valid = 1'b1;
         fas   = (i == 0);
         e6    = (i >= 30);
         m6    = e6 ? lfsr_m : 8'h00;
         #1;
         if ((corrupt_en !== e6) || (xor_mask !== m6)) bad6++;
         lfsr_m = lfsr_next(lfsr_m);
      end
      check("t6 gapped burst errors", bad6, 0);
      check("t6 frames before reset", corrupt_frames, 16'd7);
      @(negedge clk);
      valid = 1'b1;
      fas   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6 reset corrupt_en", corrupt_en, 1'b0);
      check("t6 reset xor_mask", xor_mask, 8'h00);
      check("t6 reset synced", synced, 1'b0);
      check("t6 reset col", col_cnt, 11'd0);
      check("t6 reset frames", corrupt_frames, 16'd0);
      check("t6 reset resync", resync_cnt, 8'd0);
      @(negedge clk);
      valid  = 1'b0;
      rst_n  = 1'b1;
      lfsr_m = 8'hA5;
      send_seq("t6 post-reset no FAS", 1'b0, 20, -1, -1, 1'b0, 1'b0, -1);
      check("t6 still unsynced", synced, 1'b0);
      send_seq("t6 relock", 1'b1, 5, -1, -1, 1'b0, 1'b1, -1);
      check("t6 relocked", synced, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
